// File: rtl/fpu_op_sequencer.sv
// Command sequencer between the CPU-side FPU interface and the add/sub, multiply and divide units.
// Dispatches one command at a time, bounds the wait for the unit, and holds the outcome until acknowledged.
module fpu_op_sequencer #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int DATA_W         = 32
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic [3:0]        operation,
    input  logic              ack,
    output logic              busy,
    output logic              cmd_end,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        last_op,
    output logic              err_illegal_op,
    output logic              err_timeout,
    output logic              addsub_start,
    output logic              addsub_sub,
    input  logic              addsub_done,
    input  logic [DATA_W-1:0] addsub_result,
    output logic              mul_start,
    output logic              mul_square,
    input  logic              mul_done,
    input  logic [DATA_W-1:0] mul_result,
    output logic              div_start,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_result
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DISPATCH = 3'd1,
        S_WAIT     = 3'd2,
        S_FINISH   = 3'd3,
        S_WAIT_ACK = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              cmd_end_q, cmd_end_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [3:0]        last_op_q, last_op_d;
    logic              err_ill_q, err_ill_d;
    logic              err_to_q, err_to_d;
    logic              addsub_start_q, addsub_start_d;
    logic              addsub_sub_q, addsub_sub_d;
    logic              mul_start_q, mul_start_d;
    logic              mul_square_q, mul_square_d;
    logic              div_start_q, div_start_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              sel_done_s;
    logic [DATA_W-1:0] sel_result_s;

    // Route only the done/result of the unit owning the latched opcode.
    always_comb begin
        sel_done_s   = 1'b0;
        sel_result_s = '0;
        case (last_op_q)
            4'd0, 4'd1: begin
                sel_done_s   = addsub_done;
                sel_result_s = addsub_result;
            end
            4'd2, 4'd3: begin
                sel_done_s   = mul_done;
                sel_result_s = mul_result;
            end
            4'd4: begin
                sel_done_s   = div_done;
                sel_result_s = div_result;
            end
            default: begin
                sel_done_s   = 1'b0;
                sel_result_s = '0;
            end
        endcase
    end

    // Next-state and registered-output logic of the command FSM.
    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        cmd_end_d      = cmd_end_q;
        result_d       = result_q;
        last_op_d      = last_op_q;
        err_ill_d      = err_ill_q;
        err_to_d       = err_to_q;
        addsub_start_d = 1'b0;
        mul_start_d    = 1'b0;
        div_start_d    = 1'b0;
        addsub_sub_d   = addsub_sub_q;
        mul_square_d   = mul_square_q;
        timer_d        = timer_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    last_op_d    = operation;
                    err_ill_d    = 1'b0;
                    err_to_d     = 1'b0;
                    cmd_end_d    = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = S_DISPATCH;
                    // Start pulses are registered here so they are high during DISPATCH.
                    addsub_start_d = (operation == 4'd0) || (operation == 4'd1);
                    mul_start_d    = (operation == 4'd2) || (operation == 4'd3);
                    div_start_d    = (operation == 4'd4);
                    addsub_sub_d   = (operation == 4'd1);
                    mul_square_d   = (operation == 4'd3);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DISPATCH: begin
                timer_d = '0;
                if (last_op_q <= 4'd4) begin
                    state_d = S_WAIT;
                end else begin
                    err_ill_d = 1'b1;
                    result_d  = '0;
                    state_d   = S_FINISH;
                end
            end
            S_WAIT: begin
                if (sel_done_s) begin
                    result_d = sel_result_s;
                    state_d  = S_FINISH;
                end else if (timer_q == TMR_LAST) begin
                    err_to_d = 1'b1;
                    result_d = '0;
                    state_d  = S_FINISH;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_FINISH: begin
                cmd_end_d    = 1'b1;
                addsub_sub_d = 1'b0;
                mul_square_d = 1'b0;
                state_d      = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ack) begin
                    cmd_end_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_WAIT_ACK;
                end
            end
            default: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                cmd_end_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            cmd_end_q      <= 1'b0;
            result_q       <= '0;
            last_op_q      <= 4'd0;
            err_ill_q      <= 1'b0;
            err_to_q       <= 1'b0;
            addsub_start_q <= 1'b0;
            addsub_sub_q   <= 1'b0;
            mul_start_q    <= 1'b0;
            mul_square_q   <= 1'b0;
            div_start_q    <= 1'b0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            cmd_end_q      <= cmd_end_d;
            result_q       <= result_d;
            last_op_q      <= last_op_d;
            err_ill_q      <= err_ill_d;
            err_to_q       <= err_to_d;
            addsub_start_q <= addsub_start_d;
            addsub_sub_q   <= addsub_sub_d;
            mul_start_q    <= mul_start_d;
            mul_square_q   <= mul_square_d;
            div_start_q    <= div_start_d;
            timer_q        <= timer_d;
        end
    end

    assign busy           = busy_q;
    assign cmd_end        = cmd_end_q;
    assign result         = result_q;
    assign last_op        = last_op_q;
    assign err_illegal_op = err_ill_q;
    assign err_timeout    = err_to_q;
    assign addsub_start   = addsub_start_q;
    assign addsub_sub     = addsub_sub_q;
    assign mul_start      = mul_start_q;
    assign mul_square     = mul_square_q;
    assign div_start      = div_start_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: a command-timeline model checked every cycle, plus directed
// commands with hand-computed latencies, results and flags.
module tb_fpu_op_sequencer;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  operation = 4'd0;
    logic        ack = 1'b0;
    logic        addsub_done = 1'b0, mul_done = 1'b0, div_done = 1'b0;
    logic [31:0] addsub_result = 32'd0, mul_result = 32'd0, div_result = 32'd0;
    logic        busy, cmd_end, err_illegal_op, err_timeout;
    logic        addsub_start, addsub_sub, mul_start, mul_square, div_start;
    logic [31:0] result;
    logic [3:0]  last_op;

    fpu_op_sequencer #(.TIMEOUT_CYCLES(T), .DATA_W(32)) dut (
        .clk(clk), .arst(arst), .start(start), .operation(operation), .ack(ack),
        .busy(busy), .cmd_end(cmd_end), .result(result), .last_op(last_op),
        .err_illegal_op(err_illegal_op), .err_timeout(err_timeout),
        .addsub_start(addsub_start), .addsub_sub(addsub_sub),
        .addsub_done(addsub_done), .addsub_result(addsub_result),
        .mul_start(mul_start), .mul_square(mul_square),
        .mul_done(mul_done), .mul_result(mul_result),
        .div_start(div_start), .div_done(div_done), .div_result(div_result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: command timeline anchored at the accept edge t0; t_end is the edge raising cmd_end.
    int          cyc = 0, t0 = 0, t_end = -1;
    bit          m_legal = 1'b0;
    logic        m_busy = 0, m_cmd_end = 0, m_ill = 0, m_to = 0;
    logic        m_ast = 0, m_mst = 0, m_dst = 0, m_sub = 0, m_sq = 0;
    logic [31:0] m_result = 0;
    logic [3:0]  m_last_op = 0;

    initial forever begin
        @(posedge clk or negedge arst);
        if (!arst) begin
            m_busy = 0; m_cmd_end = 0; m_ill = 0; m_to = 0; m_ast = 0; m_mst = 0;
            m_dst = 0; m_sub = 0; m_sq = 0; m_result = 0; m_last_op = 0; t_end = -1;
        end else begin
            cyc++;
            m_ast = 0; m_mst = 0; m_dst = 0;
            if (!m_busy) begin
                if (start) begin
                    m_last_op = operation; m_ill = 0; m_to = 0; m_cmd_end = 0; m_busy = 1;
                    t0 = cyc;
                    m_legal = (operation <= 4'd4);
                    m_ast = (operation <= 4'd1);
                    m_mst = (operation == 4'd2) || (operation == 4'd3);
                    m_dst = (operation == 4'd4);
                    m_sub = (operation == 4'd1);
                    m_sq  = (operation == 4'd3);
                    t_end = m_legal ? -1 : cyc + 2;
                end
            end else begin
                if (!m_legal && cyc == t0 + 1) begin
                    m_ill = 1; m_result = 0;
                end else if (m_legal && t_end < 0 && cyc >= t0 + 2) begin
                    logic        d;
                    logic [31:0] r;
                    if (m_last_op <= 4'd1) begin d = addsub_done; r = addsub_result; end
                    else if (m_last_op <= 4'd3) begin d = mul_done; r = mul_result; end
                    else begin d = div_done; r = div_result; end
                    if (d) begin
                        m_result = r; t_end = cyc + 1;
                    end else if (cyc == t0 + 1 + T) begin
                        m_to = 1; m_result = 0; t_end = cyc + 1;
                    end
                end
                if (t_end >= 0 && cyc == t_end) begin
                    m_cmd_end = 1; m_sub = 0; m_sq = 0;
                end else if (m_cmd_end && ack) begin
                    m_cmd_end = 0; m_busy = 0;
                end
            end
        end
    end

    int n_ast = 0, n_mst = 0, n_dst = 0;

    // Every-cycle comparison against the model, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        chk("busy", busy, m_busy);
        chk("cmd_end", cmd_end, m_cmd_end);
        chk("result", result, m_result);
        chk("last_op", last_op, m_last_op);
        chk("err_illegal_op", err_illegal_op, m_ill);
        chk("err_timeout", err_timeout, m_to);
        chk("addsub_start", addsub_start, m_ast);
        chk("addsub_sub", addsub_sub, m_sub);
        chk("mul_start", mul_start, m_mst);
        chk("mul_square", mul_square, m_sq);
        chk("div_start", div_start, m_dst);
        n_ast += int'(addsub_start);
        n_mst += int'(mul_start);
        n_dst += int'(div_start);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // dly>0: selected done is sampled at edge E(1+dly); dly==0: done never comes.
    task automatic run(input logic [3:0] op, input int dly, input logic [31:0] res,
                       input bit stray, input int exp_lat, input logic [31:0] exp_res,
                       input logic exp_ill, input logic exp_to);
        int lat = -1;
        int a0 = n_ast, m0 = n_mst, d0 = n_dst;
        addsub_result = (op <= 4'd1) ? res : 32'h0BAD_0001;
        mul_result    = (op == 4'd2 || op == 4'd3) ? res : 32'h0BAD_0002;
        div_result    = (op == 4'd4) ? res : 32'h0BAD_0003;
        operation = op;
        start = 1'b1;
        for (int j = 1; j <= 40 && lat < 0; j++) begin
            @(negedge clk);
            if (cmd_end === 1'b1) lat = j - 1;
            #1;
            start = 1'b0;
            addsub_done = 1'b0; mul_done = 1'b0; div_done = 1'b0;
            if (dly > 0 && j == 1 + dly) begin
                if (op <= 4'd1) addsub_done = 1'b1;
                else if (op <= 4'd3) mul_done = 1'b1;
                else div_done = 1'b1;
            end
            if (stray && j == 2) begin
                mul_done = 1'b1; div_done = 1'b1;
            end
        end
        addsub_done = 1'b0; mul_done = 1'b0; div_done = 1'b0;
        chk("latency_edges", lat, exp_lat);
        chk("lit_result", result, exp_res);
        chk("lit_err_illegal", err_illegal_op, exp_ill);
        chk("lit_err_timeout", err_timeout, exp_to);
        if (stray) begin
            operation = 4'd7; start = 1'b1;
        end
        tick();
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0; start = 1'b0;
        tick();
        chk("lit_busy_after_ack", busy, 1'b0);
        chk("lit_last_op", last_op, op);
        chk("lit_addsub_pulses", n_ast - a0, (op <= 4'd1) ? 1 : 0);
        chk("lit_mul_pulses", n_mst - m0, (op == 4'd2 || op == 4'd3) ? 1 : 0);
        chk("lit_div_pulses", n_dst - d0, (op == 4'd4) ? 1 : 0);
    endtask

    initial begin
        repeat (3) tick();
        arst = 1'b1;
        tick();
        chk("lit_reset_busy", busy, 1'b0);
        chk("lit_reset_result", result, 32'h0);
        chk("lit_reset_last_op", last_op, 4'd0);

        run(4'd0, 5, 32'h4040_0000, 1'b0, 7, 32'h4040_0000, 1'b0, 1'b0);
        run(4'd3, 1, 32'h4110_0000, 1'b0, 3, 32'h4110_0000, 1'b0, 1'b0);
        run(4'd6, 0, 32'h1234_5678, 1'b0, 2, 32'h0, 1'b1, 1'b0);
        run(4'd4, 0, 32'h5555_AAAA, 1'b0, 18, 32'h0, 1'b0, 1'b1);
        run(4'd4, 16, 32'h3F80_0000, 1'b0, 18, 32'h3F80_0000, 1'b0, 1'b0);
        run(4'd1, 4, 32'hC000_0000, 1'b1, 6, 32'hC000_0000, 1'b0, 1'b0);
        run(4'd12, 0, 32'h0, 1'b0, 2, 32'h0, 1'b1, 1'b0);

        // Reset in the middle of a multiply, then a late done that must be ignored.
        operation = 4'd2; mul_result = 32'h4000_0000; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("lit_mul_busy_before_reset", busy, 1'b1);
        arst = 1'b0;
        #1;
        chk("lit_arst_busy", busy, 1'b0);
        chk("lit_arst_result", result, 32'h0);
        chk("lit_arst_last_op", last_op, 4'd0);
        chk("lit_arst_flags", {cmd_end, err_illegal_op, err_timeout, mul_start, mul_square},
            5'b0);
        tick();
        arst = 1'b1;
        tick();
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        tick();
        tick();
        chk("lit_late_done_busy", busy, 1'b0);
        chk("lit_late_done_cmd_end", cmd_end, 1'b0);

        run(4'd0, 2, 32'h4100_0000, 1'b0, 4, 32'h4100_0000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
